// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV32M multiply/divide unit.
// One operand bit per cycle; every op (including divide-by-zero and signed overflow)
// takes the same path IDLE -> CALC(32) -> FIX -> DONE, so latency is fixed.
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [4:0]        rd_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic [4:0]        rd_o
);

  localparam int W = DATA_W;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_next;

  logic [2:0]     op_q;
  logic [2*W-1:0] acc;
  logic [W-1:0]   operand;
  logic           sign_a;
  logic           sign_b;
  logic           b_zero;
  logic [4:0]     counter;

  logic           a_signed;
  logic           b_signed;
  logic           sa_in;
  logic           sb_in;
  logic [W-1:0]   abs_a;
  logic [W-1:0]   abs_b;

  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic           div_ge;
  logic [2*W-1:0] acc_step;

  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;
  logic [W-1:0]   result_fix;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic and status outputs
  always_comb begin
    state_next = state;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE: if (start_i) state_next = CALC;
      CALC: begin
        busy_o = 1'b1;
        if (counter == 5'd31) state_next = FIX;
      end
      FIX: begin
        busy_o     = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        busy_o     = 1'b1;
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand signedness and magnitudes; |0x80000000| stays 0x80000000 read as unsigned
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_i)
      3'd1, 3'd4, 3'd6: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'd2:             a_signed = 1'b1;
      default:          ;
    endcase
    sa_in = a_signed & a_i[W-1];
    sb_in = b_signed & b_i[W-1];
    abs_a = sa_in ? (-a_i) : a_i;
    abs_b = sb_in ? (-b_i) : b_i;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  // acc holds {product hi, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : '0);
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_ge    = div_shift >= {1'b0, operand};
    div_diff  = div_shift - {1'b0, operand};
    if (op_q[2]) begin
      if (div_ge) acc_step = {div_diff[W-1:0], acc[W-2:0], 1'b1};
      else        acc_step = {div_shift[W-1:0], acc[W-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[W-1:1]};
    end
  end

  // Sign correction and result selection. A zero divisor clears the quotient
  // sign so DIV/0 yields all ones; the remainder then equals a with a's sign.
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? (-acc) : acc;
    quo_fix  = ((sign_a ^ sign_b) && !b_zero) ? (-acc[W-1:0]) : acc[W-1:0];
    rem_fix  = sign_a ? (-acc[2*W-1:W]) : acc[2*W-1:W];
    case (op_q)
      3'd0:             result_fix = prod_fix[W-1:0];
      3'd1, 3'd2, 3'd3: result_fix = prod_fix[2*W-1:W];
      3'd4, 3'd5:       result_fix = quo_fix;
      default:          result_fix = rem_fix;
    endcase
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= '0;
      acc      <= '0;
      operand  <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      b_zero   <= 1'b0;
      counter  <= '0;
      result_o <= '0;
      rd_o     <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          op_q    <= op_i;
          rd_o    <= rd_i;
          sign_a  <= sa_in;
          sign_b  <= sb_in;
          b_zero  <= (b_i == '0);
          counter <= '0;
          if (op_i[2]) begin
            acc     <= {{W{1'b0}}, abs_a};
            operand <= abs_b;
          end else begin
            acc     <= {{W{1'b0}}, abs_b};
            operand <= abs_a;
          end
        end
        CALC: begin
          acc     <= acc_step;
          counter <= counter + 5'd1;
        end
        FIX: result_o <= result_fix;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed results for muldiv_unit.
module tb_muldiv_unit;

  logic        clk_i   = 1'b0;
  logic        rst_ni  = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i    = '0;
  logic [31:0] a_i     = '0;
  logic [31:0] b_i     = '0;
  logic [4:0]  rd_i    = '0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3,
                         DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  // Done is expected in the cycle following edge T+33 (T = start-sampling edge)
  localparam int DONE_EDGE = 33;

  muldiv_unit #(.DATA_W(32)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .rd_i     (rd_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .rd_o     (rd_o)
  );

  // Free-running clock, 10 time units per period
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one op (called #1 after a rising edge), then check latency, result, rd and pulse width
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd, input logic [31:0] expected);
    int lat;
    lat     = 0;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    rd_i    = rd;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    op_i    = 3'($urandom_range(0, 7));
    a_i     = $urandom;
    b_i     = $urandom;
    rd_i    = 5'($urandom_range(0, 31));
    for (int n = 1; n <= DONE_EDGE + 6 && lat == 0; n++) begin
      @(posedge clk_i); #1;
      if (done_o) lat = n;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(DONE_EDGE));
    checkOutput({tag, " busy in done"}, {31'b0, busy_o}, 32'd1);
    checkOutput({tag, " result"}, result_o, expected);
    checkOutput({tag, " rd"}, {27'b0, rd_o}, {27'b0, rd});
    @(posedge clk_i); #1;
    checkOutput({tag, " done width"}, {31'b0, done_o}, 32'd0);
    checkOutput({tag, " idle after done"}, {31'b0, busy_o}, 32'd0);
  endtask

  // Directed test sequence
  initial begin
    int dones;
    #1;
    checkOutput("reset busy", {31'b0, busy_o}, 32'd0);
    checkOutput("reset done", {31'b0, done_o}, 32'd0);
    checkOutput("reset result", result_o, 32'd0);
    checkOutput("reset rd", {27'b0, rd_o}, 32'd0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    applyStimulus("MUL 7*-3", MUL, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB);
    applyStimulus("MULH min*min", MULH, 32'h80000000, 32'h80000000, 5'd2, 32'h40000000);
    applyStimulus("MULHU max*max", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE);
    applyStimulus("MULHSU -1*max", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF);
    applyStimulus("DIV -7/2", DIV, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD);
    applyStimulus("REM -7,2", REM, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF);
    applyStimulus("DIVU 100/7", DIVU, 32'd100, 32'd7, 5'd7, 32'd14);
    applyStimulus("REMU 100,7", REMU, 32'd100, 32'd7, 5'd8, 32'd2);
    applyStimulus("DIV 5/0", DIV, 32'd5, 32'd0, 5'd10, 32'hFFFFFFFF);
    applyStimulus("DIVU 5/0", DIVU, 32'd5, 32'd0, 5'd11, 32'hFFFFFFFF);
    applyStimulus("REM 5,0", REM, 32'd5, 32'd0, 5'd12, 32'd5);
    applyStimulus("REMU 5,0", REMU, 32'd5, 32'd0, 5'd13, 32'd5);
    applyStimulus("DIV ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000);
    applyStimulus("REM ovf", REM, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0);

    // Start while busy must be ignored: one done, original operands and rd
    op_i = MUL; a_i = 32'd3; b_i = 32'd4; rd_i = 5'd9; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    dones = 0;
    for (int n = 1; n <= DONE_EDGE + 12; n++) begin
      if (n == 5) begin
        op_i = MUL; a_i = 32'd1; b_i = 32'd1; rd_i = 5'd2; start_i = 1'b1;
      end
      if (n == 6) start_i = 1'b0;
      @(posedge clk_i); #1;
      if (done_o) begin
        dones++;
        checkOutput("busy start result", result_o, 32'd12);
        checkOutput("busy start rd", {27'b0, rd_o}, 32'd9);
      end
    end
    checkOutput("busy start done count", 32'(dones), 32'd1);

    // Reset during CALC aborts the op immediately
    op_i = MUL; a_i = 32'd3; b_i = 32'd4; rd_i = 5'd17; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    checkOutput("abort busy", {31'b0, busy_o}, 32'd0);
    checkOutput("abort result", result_o, 32'd0);
    checkOutput("abort rd", {27'b0, rd_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    dones = 0;
    for (int n = 1; n <= DONE_EDGE + 10; n++) begin
      @(posedge clk_i); #1;
      if (done_o) dones++;
    end
    checkOutput("abort no done", 32'(dones), 32'd0);
    applyStimulus("post-reset DIVU", DIVU, 32'd100, 32'd7, 5'd21, 32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
